// File: rtl/fu_issue_arbiter.sv
// Functional-unit issue arbiter: grants up to three RS slots a specific unit
// instance each cycle and tracks occupancy of the multi-cycle LS/MULT units.
module fu_issue_arbiter #(
  parameter int MULT_LAT = 4,
  parameter int CNTW     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req_valid,
  input  logic [5:0] req_class,
  input  logic [7:0] unit_hold,
  input  logic [1:0] ls_done,
  input  logic       squash,
  output logic [2:0] gnt,
  output logic [8:0] gnt_unit,
  output logic [7:0] fu_ready
);

  localparam logic [CNTW-1:0] MCNT_INIT = CNTW'(MULT_LAT - 1);
  localparam logic [CNTW-1:0] MCNT_ONE  = CNTW'(1);

  logic [7:0]            busy_q, busy_d;
  logic [1:0][CNTW-1:0]  mcnt_q, mcnt_d;
  logic [7:0]            free;
  logic [7:0]            taken;
  logic [7:0]            cand;
  logic [2:0]            unit_id;

  function automatic logic [7:0] class_mask(input logic [1:0] cls);
    case (cls)
      2'd0:    class_mask = 8'h07;
      2'd1:    class_mask = 8'h18;
      2'd2:    class_mask = 8'h60;
      default: class_mask = 8'h80;
    endcase
  endfunction

  function automatic logic [2:0] pick_lowest(input logic [7:0] avail);
    pick_lowest = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (avail[k]) pick_lowest = 3'(k);
    end
  endfunction

  assign fu_ready = ~busy_q;
  assign free     = fu_ready & ~unit_hold & {8{~squash & ~reset}};

  // Sequential-priority allocation; class is only looked at for valid slots
  // so an X class on an idle slot cannot leak into the outputs.
  always_comb begin
    gnt      = '0;
    gnt_unit = '0;
    taken    = '0;
    cand     = '0;
    unit_id  = '0;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i]) begin
        cand = free & ~taken & class_mask(req_class[2*i +: 2]);
        if (|cand) begin
          unit_id              = pick_lowest(cand);
          gnt[i]               = 1'b1;
          gnt_unit[3*i +: 3]   = unit_id;
          taken[unit_id]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    mcnt_d = mcnt_q;
    if (squash) begin
      busy_d = '0;
      mcnt_d = '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (taken[3+j])      busy_d[3+j] = 1'b1;
        else if (ls_done[j]) busy_d[3+j] = 1'b0;

        // Grant loads LAT-1; the unit frees on the edge where the count is 1.
        if (taken[5+j]) begin
          busy_d[5+j] = 1'b1;
          mcnt_d[j]   = MCNT_INIT;
        end else if (busy_q[5+j]) begin
          if (mcnt_q[j] == MCNT_ONE) begin
            busy_d[5+j] = 1'b0;
            mcnt_d[j]   = '0;
          end else begin
            mcnt_d[j]   = mcnt_q[j] - MCNT_ONE;
          end
        end
      end
    end
    busy_d[2:0] = 3'b000;
    busy_d[7]   = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      mcnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      mcnt_q <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Scoreboard bench for fu_issue_arbiter: directed vectors push expected
// {gnt, gnt_unit, fu_ready}; a negedge monitor pops and compares.
module tb_fu_issue_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req_valid = '0;
  logic [5:0] req_class = '0;
  logic [7:0] unit_hold = '0;
  logic [1:0] ls_done = '0;
  logic       squash = 1'b0;
  logic [2:0] gnt;
  logic [8:0] gnt_unit;
  logic [7:0] fu_ready;

  int compared = 0;
  int failed   = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];

  fu_issue_arbiter #(.MULT_LAT(4), .CNTW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_class (req_class),
    .unit_hold (unit_hold),
    .ls_done   (ls_done),
    .squash    (squash),
    .gnt       (gnt),
    .gnt_unit  (gnt_unit),
    .fu_ready  (fu_ready)
  );

  always #5 clock = ~clock;

  task automatic step(input string nm, input logic [2:0] rv, input logic [5:0] cls,
                      input logic [7:0] hold, input logic [1:0] lsd, input logic sq,
                      input logic rs, input logic [2:0] eg, input logic [8:0] egu,
                      input logic [7:0] er);
    @(posedge clock);
    #1;
    req_valid = rv;
    req_class = cls;
    unit_hold = hold;
    ls_done   = lsd;
    squash    = sq;
    reset     = rs;
    name_q.push_back(nm);
    exp_q.push_back({eg, egu, er});
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      compared++;
      if ({gnt, gnt_unit, fu_ready} !== e) begin
        failed++;
        $display("FAIL %s: got gnt=%b unit=%b rdy=%h, want gnt=%b unit=%b rdy=%h",
                 n, gnt, gnt_unit, fu_ready, e[19:17], e[16:8], e[7:0]);
      end
    end
  end

  initial begin
    //    name          rv      class       hold   lsd  sq  rs  gnt     gnt_unit        rdy
    step("in_reset",    3'b111, 6'b000000, 8'h00, 2'b00, 0, 1, 3'b000, 9'b000_000_000, 8'hFF);
    step("idle",        3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hFF);
    step("alu3",        3'b111, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b111, 9'b010_001_000, 8'hFF);
    step("mult3",       3'b111, 6'b101010, 8'h00, 2'b00, 0, 0, 3'b011, 9'b000_110_101, 8'hFF);
    step("mult_busy1",  3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'h9F);
    step("mult_busy2",  3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'h9F);
    step("mult_busy3",  3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'h9F);
    step("mult_regnt",  3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_101, 8'hFF);
    step("m5_cnt_a",    3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hDF);
    step("m5_cnt_b",    3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hDF);
    step("m5_cnt_c",    3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hDF);
    step("m5_free",     3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hFF);
    step("br_br_ls",    3'b111, 6'b011111, 8'h00, 2'b00, 0, 0, 3'b101, 9'b011_000_111, 8'hFF);
    step("ls_unit4",    3'b001, 6'b000001, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_100, 8'hF7);
    step("ls_denied",   3'b001, 6'b000001, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hE7);
    step("ls_done_cyc", 3'b001, 6'b000001, 8'h00, 2'b01, 0, 0, 3'b000, 9'b000_000_000, 8'hE7);
    step("ls_regnt3",   3'b001, 6'b000001, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_011, 8'hEF);
    step("ls_done_both",3'b000, 6'b000000, 8'h00, 2'b11, 0, 0, 3'b000, 9'b000_000_000, 8'hE7);
    step("ls_done_idle",3'b000, 6'b000000, 8'h00, 2'b11, 0, 0, 3'b000, 9'b000_000_000, 8'hFF);
    step("hold_alu0",   3'b111, 6'b000000, 8'h01, 2'b00, 0, 0, 3'b011, 9'b000_010_001, 8'hFF);
    step("hold_mult5",  3'b001, 6'b000010, 8'h20, 2'b00, 0, 0, 3'b001, 9'b000_000_110, 8'hFF);
    step("mult_ls",     3'b011, 6'b000110, 8'h00, 2'b00, 0, 0, 3'b011, 9'b000_011_101, 8'hBF);
    step("squash",      3'b111, 6'b000000, 8'h00, 2'b01, 1, 0, 3'b000, 9'b000_000_000, 8'h97);
    step("post_squash", 3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_101, 8'hFF);
    step("alu_m5busy",  3'b111, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b111, 9'b010_001_000, 8'hDF);
    step("async_reset", 3'b111, 6'b000000, 8'h00, 2'b00, 0, 1, 3'b000, 9'b000_000_000, 8'hFF);
    step("post_reset",  3'b001, 6'b000010, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_101, 8'hFF);
    step("x_class",     3'b001, 6'bxxxx00, 8'h00, 2'b00, 0, 0, 3'b001, 9'b000_000_000, 8'hDF);
    step("drain",       3'b000, 6'b000000, 8'h00, 2'b00, 0, 0, 3'b000, 9'b000_000_000, 8'hDF);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Shares the functional units between the three issue slots that the reservation station presents each cycle.
- Tracks the busy state of the multi-cycle units (load/store and multiply) and grants each requesting slot a specific unit instance.
- Publishes a registered per-unit ready vector that the reservation station consumes as its FU-ready input.
- Sits between RS select logic and the FU bank; owns no datapath, only allocation state.

Parameters:
- MULT_LAT, 4: multiply occupancy in cycles, counted from grant to the cycle in which the unit is grantable again. Legal range 2..16.
- CNTW, 4: multiply countdown counter width. Must satisfy 2**CNTW >= MULT_LAT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  3  slot i requests a unit this cycle. Slot 0 is the oldest and has highest priority.
- req_class  in  6  2 bits per slot, slot i at [2i+1:2i]: 0=ALU, 1=LS, 2=MULT, 3=BRANCH.
- unit_hold  in  8  per unit: result register occupied and not yet accepted by CDB; unit must not be granted.
- ls_done  in  2  per LS unit: one-cycle pulse, access complete.
- squash  in  1  pipeline flush.
- gnt  out  3  slot i granted this cycle (combinational).
- gnt_unit  out  9  3 bits per slot: granted unit id. 0-2 ALU0-2, 3-4 LS0-1, 5-6 MULT0-1, 7 BR. Value is 0 when gnt[i]=0.
- fu_ready  out  8  registered: unit id k is not busy. Bit order matches the unit id.

Behaviour:
- State:
  - busy_q[7:0]. Bits 0-2 and 7 are tied 0, since ALU and BR units are single-cycle pipelined.
  - mcnt_q[1:0], CNTW bits each.
- fu_ready = ~busy_q. It is a direct register output with no combinational path from the inputs.
- A unit is free this cycle when fu_ready[k] & ~unit_hold[k] & ~squash & ~reset.
- Arbitration is combinational, in sequential priority order: slot 0, then slot 1, then slot 2.
  - An invalid slot consumes nothing.
  - A valid slot takes the lowest-index free unit of its class not already taken by a higher-priority slot this cycle.
  - If no such unit exists, gnt[i]=0 and that slot's gnt_unit=0.
- A younger slot may be granted while an older slot is denied (different classes). Allocation is not in-order.
- LS grant to unit k: busy_q[k] <= 1 at the edge. ls_done[k] clears it at the edge, and the unit is grantable in the following cycle.
- ls_done on an idle LS unit is ignored.
- MULT grant to unit k:
  - busy_q[k] <= 1 and mcnt_q <= MULT_LAT-1.
  - Each cycle while busy, mcnt_q decrements.
  - When mcnt_q==1 at an edge, busy clears and mcnt_q <= 0.
  - Result: a grant at cycle t means the unit is regrantable at cycle t+MULT_LAT.
- A busy unit can never be granted, so a grant and a completion cannot target the same unit in the same cycle.
- squash, cycle-level:
  - All gnt=0 in the squash cycle.
  - At the edge, busy_q <= 0 and mcnt_q <= 0; ls_done in that cycle is irrelevant.
  - fu_ready = 8'hFF from the next cycle.
- reset (asynchronous): busy_q=0, mcnt_q=0, fu_ready=8'hFF, gnt=0, gnt_unit=0 while reset is asserted, regardless of req_valid.
- Deasserting reset mid-countdown is not special: state is already cleared.
- unit_hold only masks grants. It never changes busy_q or mcnt_q, and a busy MULT keeps counting while held.
- X on req_class of an invalid slot must not propagate to any output.

Test Plan:
- Post-reset, req_valid=3'b111, all class ALU -> gnt=111, gnt_unit = {2,1,0} (slot2..slot0); fu_ready=8'hFF stays unchanged.
- Cycle 0: slot0 MULT, slot1 MULT, slot2 MULT -> gnt=011, units 5 and 6. Next cycle fu_ready[6:5]=00. With MULT_LAT=4, a MULT request is denied in cycles 1-3 and granted unit 5 in cycle 4.
- Slot0 BRANCH, slot1 BRANCH, slot2 LS -> gnt=101, slot2 unit 3. Next cycle, LS request -> unit 4. Third LS request denied until ls_done[0] pulses, then granted unit 3 in the cycle after the pulse.
- unit_hold=8'b00000001 with three ALU requests -> gnt=011, units 1 and 2. Slot2 is denied and gnt_unit slot2=0.
- Two MULT units busy (count 2) and LS0 busy, then assert squash with req_valid=111 -> gnt=000 that cycle; fu_ready=8'hFF the next cycle; a MULT request in the next cycle gets unit 5.
- Assert reset asynchronously mid-cycle while MULT is counting and req_valid=111 -> gnt=0 and fu_ready=8'hFF immediately, without waiting for a clock edge.
